counter_slot_arbiter: RTL
=========================

# counter_slot_arbiter

Shares one 4-bit slot counter among several requesters. Each requester asks for a timed slot of programmable length. The block grants the counter to one requester at a time and runs the count for that requester. It signals slot completion, then re-arbitrates with no bubble between slots. It sits in front of the `simple_counter`-style datapath and owns its sequencing.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `CNT_W`, 4: counter and slot-length width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `req`  in  N_REQ  per-requester request level.
- `req_len`  in  N_REQ*CNT_W  slot length code for requester i, at `[i*CNT_W +: CNT_W]`; slot lasts code+1 cycles.
- `abort`  in  1  terminate the current slot early.
- `grant`  out  N_REQ  one-hot owner of the counter; all-zero when idle.
- `owner`  out  $clog2(N_REQ)  index of current owner; 0 when idle.
- `busy`  out  1  a slot is in progress.
- `count_out`  out  CNT_W  cycle index within the slot (0..len).
- `done`  out  1  one-cycle pulse on the final cycle of a completed slot.

## Operation
- Reset values: `grant`=0, `owner`=0, `busy`=0, `count_out`=0, `done`=0, state=IDLE, RR pointer=0.
- The FSM has two states: IDLE and RUN.

IDLE:
- If any `req` bit is set, arbitrate and latch the winner's `req_len` into `slot_len`.
- On the next edge, move to RUN with `grant[w]`=1, `owner`=w, `busy`=1, `count_out`=0.

RUN:
- `count_out` increments by 1 each cycle.
- `done` = (`count_out`==`slot_len`) && RUN. It is decoded from registers only, with no input-to-output combinational path.
- On the final cycle (`count_out`==`slot_len`), with `abort` low:
  - If any `req` is set, arbitrate again. The new winner is granted on the next edge with `count_out`=0 (back-to-back).
  - Otherwise, return to IDLE with all outputs at their reset values.
- `abort`=1 in any RUN cycle forces IDLE on the next edge and clears `grant`, `busy` and `count_out`. There is no re-arbitration that edge.
- `abort` on the final cycle: `done` is still 1 in that cycle, and the next state is IDLE without re-arbitration.
- `abort` in IDLE is ignored.
- `req` and `req_len` are sampled only at arbitration. Dropping `req` or changing `req_len` mid-slot has no effect.
- The current owner may win again at the next arbitration, subject to the arbitration rule in Configuration.
- `req_len`=0 gives a one-cycle slot: `count_out`=0 and `done`=1 in the same cycle.
- `count_out` never exceeds `slot_len`, so it never wraps.

## Timing
- Request-to-grant latency: `req` seen high at edge T (IDLE) gives `grant` at T+1.
- A slot of code L occupies exactly L+1 cycles of `grant`.
- Back-to-back slots have zero idle cycles between grants.
- Async reset mid-slot clears everything immediately. After deassertion, the first arbitration happens on the first edge that sees `req`.
- All outputs are registered except `done`, which is a decode of registered state.

## Configuration
- Macro: `COUNTER_SLOT_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - Search starts at the RR pointer and wraps modulo N_REQ.
  - After granting w, the pointer becomes (w+1) mod N_REQ.
  - The pointer is unchanged by abort.
- Undefined: fixed priority, lowest index wins. The pointer logic is removed.

## Test plan
- Reset, then `req`=4'b0100 with `req_len[2]`=3 → `grant`=4'b0100 one cycle later; `count_out` 0,1,2,3; `done`=1 with `count_out`=3; then `grant`=0, `busy`=0.
- `req`=4'b1111, all lengths 0, RR enabled → grants 0,1,2,3,0 on consecutive cycles; `done`=1 on every cycle.
- Same stimulus with the macro undefined → `grant`=4'b0001 every cycle (requester 0 starves the others).
- Slot of length 7, `abort` pulsed at `count_out`=2 → `grant`, `busy`, `count_out`=0 the next cycle; `done` never asserted.
- `abort` on the final cycle while `req`=4'b0010 pending → `done`=1 that cycle; one IDLE cycle; `grant`=4'b0010 the cycle after.
- `rst_n` asserted asynchronously mid-slot at `count_out`=5 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter: grants a shared slot counter to one requester at a time.
// Optional round-robin arbitration: define COUNTER_SLOT_ARB_ROUND_ROBIN_EN
// (otherwise fixed priority, lowest index wins).
module counter_slot_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   req_len,
    input  logic                     abort,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [CNT_W-1:0]         count_out,
    output logic                     done
);

    localparam int OW = $clog2(N_REQ);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [N_REQ-1:0] grant_nx;
    logic [OW-1:0]    owner_nx;
    logic [CNT_W-1:0] count_nx;
    logic [CNT_W-1:0] slot_len, slot_len_nx;
    logic [OW-1:0]    win;
    logic             any_req;
    logic             last;
    logic             arb;

`ifdef COUNTER_SLOT_ARB_ROUND_ROBIN_EN
    logic [OW-1:0] ptr, ptr_nx;
    logic          found;
    int            idx;

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: lowest requesting index wins
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) win = OW'(i);
    end
`endif

    assign any_req = |req;
    assign last    = (count_out == slot_len);
    assign busy    = (state == RUN);
    assign done    = (state == RUN) && last;

    // Next-state: arbitrate from IDLE or on a clean final cycle, else count or abort
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        owner_nx    = owner;
        count_nx    = count_out;
        slot_len_nx = slot_len;
        arb         = 1'b0;
`ifdef COUNTER_SLOT_ARB_ROUND_ROBIN_EN
        ptr_nx      = ptr;
`endif
        if (state == IDLE) begin
            arb = any_req;
        end else if (abort || (last && !any_req)) begin
            state_nx    = IDLE;
            grant_nx    = '0;
            owner_nx    = '0;
            count_nx    = '0;
            slot_len_nx = '0;
        end else if (last) begin
            arb = 1'b1;
        end else begin
            count_nx = count_out + CNT_W'(1);
        end
        if (arb) begin
            state_nx    = RUN;
            grant_nx    = N_REQ'(1) << win;
            owner_nx    = win;
            count_nx    = '0;
            slot_len_nx = req_len[win*CNT_W +: CNT_W];
`ifdef COUNTER_SLOT_ARB_ROUND_ROBIN_EN
            ptr_nx      = (win == OW'(N_REQ - 1)) ? '0 : win + OW'(1);
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            count_out <= '0;
            slot_len  <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            owner     <= owner_nx;
            count_out <= count_nx;
            slot_len  <= slot_len_nx;
        end
    end

`ifdef COUNTER_SLOT_ARB_ROUND_ROBIN_EN
    // Round-robin pointer, advanced only when a grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nx;
    end
`endif

endmodule
